// File: rtl/cacheline_burst_adaptor.sv
// Memory-side responder for the cache's line port: one LINE_W read or write becomes a
// BEATS-beat burst on the memory port, then a one-cycle resp_o back to the cache.
module cacheline_burst_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFS   = $clog2(LINE_W / 8);
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [K_W-1:0]    k_reg, k_next;
    logic [31:0]       address_reg;
    logic [BEAT_W-1:0] line_reg [BEATS];
    logic [BEAT_W-1:0] wbuf_reg [BEATS];
    logic              accept;
    logic              load_wbuf;
    logic              unused_addr_bits;

    // Offset bits inside the line never reach memory; bursts are always line-aligned.
    assign unused_addr_bits = ^address_i[OFS-1:0];

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        accept     = 1'b0;
        load_wbuf  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Write wins when both are raised so an illegal request cannot hang us.
                if (write_i) begin
                    state_next = WRITE;
                    accept     = 1'b1;
                    load_wbuf  = 1'b1;
                    k_next     = '0;
                end else if (read_i) begin
                    state_next = READ;
                    accept     = 1'b1;
                    k_next     = '0;
                end
            end
            READ, WRITE: begin
                if (resp_i) begin
                    k_next = k_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            address_reg <= '0;
            for (int i = 0; i < BEATS; i++) begin
                line_reg[i] <= '0;
                wbuf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            if (accept) begin
                address_reg <= {address_i[31:OFS], {OFS{1'b0}}};
            end
            if (load_wbuf) begin
                for (int i = 0; i < BEATS; i++) begin
                    wbuf_reg[i] <= line_i[i*BEAT_W +: BEAT_W];
                end
            end
            if (state_reg == READ && resp_i) begin
                line_reg[k_reg] <= burst_i;
            end
        end
    end

    // Memory-side controls decode from the state register only: no input-to-output paths.
    assign read_o    = (state_reg == READ);
    assign write_o   = (state_reg == WRITE);
    assign resp_o    = (state_reg == DONE);
    assign address_o = address_reg;
    assign burst_o   = (state_reg == WRITE) ? wbuf_reg[k_reg] : '0;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_line_out
            assign line_o[gi*BEAT_W +: BEAT_W] = line_reg[gi];
        end
    endgenerate

endmodule
